// File: rtl/tmds_rx_align.sv
// TMDS receive channel: slips the external deserializer until control tokens
// line up, then decodes 10b words into pixel data, data-enable and control bits.
module tmds_rx_align #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 4,
  parameter int LOSS_WINDOW   = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] tmds_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_WINDOW + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 32'sd1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 32'sd1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 32'sd1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 32'sd1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  logic [1:0]        state_r, state_s;
  logic [RUN_W-1:0]  run_cnt_r, run_cnt_s;
  logic [WIN_W-1:0]  win_cnt_r, win_cnt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic [LOSS_W-1:0] loss_cnt_r, loss_cnt_s;
  logic              is_token_s;
  logic [1:0]        token_ctrl_s;
  logic              de_s;
  logic [1:0]        ctrl_s;
  logic [7:0]        data_s;

  // Control token recognition
  always_comb begin
    is_token_s   = 1'b0;
    token_ctrl_s = 2'b00;
    case (tmds_i)
      10'h354: begin is_token_s = 1'b1; token_ctrl_s = 2'b00; end
      10'h0AB: begin is_token_s = 1'b1; token_ctrl_s = 2'b01; end
      10'h154: begin is_token_s = 1'b1; token_ctrl_s = 2'b10; end
      10'h2AB: begin is_token_s = 1'b1; token_ctrl_s = 2'b11; end
      default: begin is_token_s = 1'b0; token_ctrl_s = 2'b00; end
    endcase
  end

  // Alignment FSM next-state and counter logic
  always_comb begin
    state_s    = state_r;
    run_cnt_s  = run_cnt_r;
    win_cnt_s  = win_cnt_r;
    wait_cnt_s = wait_cnt_r;
    loss_cnt_s = loss_cnt_r;
    case (state_r)
      ST_SEARCH: begin
        // Lock takes priority over an expiring search window.
        if (is_token_s && (run_cnt_r == RUN_LAST)) begin
          state_s    = ST_LOCKED;
          run_cnt_s  = {RUN_W{1'b0}};
          win_cnt_s  = {WIN_W{1'b0}};
          loss_cnt_s = {LOSS_W{1'b0}};
        end else if (win_cnt_r == WIN_LAST) begin
          state_s   = ST_SLIP;
          run_cnt_s = {RUN_W{1'b0}};
          win_cnt_s = {WIN_W{1'b0}};
        end else begin
          run_cnt_s = is_token_s ? (run_cnt_r + RUN_W'(1'b1)) : {RUN_W{1'b0}};
          win_cnt_s = win_cnt_r + WIN_W'(1'b1);
        end
      end
      ST_SLIP: begin
        state_s    = ST_WAIT;
        wait_cnt_s = {WAIT_W{1'b0}};
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s    = ST_SEARCH;
          wait_cnt_s = {WAIT_W{1'b0}};
          run_cnt_s  = {RUN_W{1'b0}};
          win_cnt_s  = {WIN_W{1'b0}};
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1'b1);
        end
      end
      ST_LOCKED: begin
        if (is_token_s) begin
          loss_cnt_s = {LOSS_W{1'b0}};
        end else if (loss_cnt_r == LOSS_LAST) begin
          state_s    = ST_SEARCH;
          loss_cnt_s = {LOSS_W{1'b0}};
          run_cnt_s  = {RUN_W{1'b0}};
          win_cnt_s  = {WIN_W{1'b0}};
        end else begin
          loss_cnt_s = loss_cnt_r + LOSS_W'(1'b1);
        end
      end
      default: begin
        state_s    = ST_SEARCH;
        run_cnt_s  = {RUN_W{1'b0}};
        win_cnt_s  = {WIN_W{1'b0}};
        wait_cnt_s = {WAIT_W{1'b0}};
        loss_cnt_s = {LOSS_W{1'b0}};
      end
    endcase
  end

  // Decoded outputs follow the next state so the locking word is already visible
  always_comb begin
    de_s   = 1'b0;
    ctrl_s = 2'b00;
    data_s = 8'h00;
    if (state_s == ST_LOCKED) begin
      if (is_token_s) begin
        de_s   = 1'b0;
        ctrl_s = token_ctrl_s;
        data_s = 8'h00;
      end else begin
        de_s   = 1'b1;
        ctrl_s = ctrl_o;
        data_s = tmds_decode(tmds_i);
      end
    end else begin
      de_s   = 1'b0;
      ctrl_s = 2'b00;
      data_s = 8'h00;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_SEARCH;
      run_cnt_r  <= {RUN_W{1'b0}};
      win_cnt_r  <= {WIN_W{1'b0}};
      wait_cnt_r <= {WAIT_W{1'b0}};
      loss_cnt_r <= {LOSS_W{1'b0}};
      bitslip_o  <= 1'b0;
      locked_o   <= 1'b0;
      de_o       <= 1'b0;
      ctrl_o     <= 2'b00;
      data_o     <= 8'h00;
    end else begin
      state_r    <= state_s;
      run_cnt_r  <= run_cnt_s;
      win_cnt_r  <= win_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      loss_cnt_r <= loss_cnt_s;
      bitslip_o  <= (state_s == ST_SLIP);
      locked_o   <= (state_s == ST_LOCKED);
      de_o       <= de_s;
      ctrl_o     <= ctrl_s;
      data_o     <= data_s;
    end
  end

endmodule

// File: tb/tb_tmds_rx_align.sv
// Directed bench for tmds_rx_align: lock, slip cadence, decode, control map,
// loss of lock and reset during the post-slip wait.
module tb_tmds_rx_align;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [9:0] tmds_i;
  logic       bitslip_o;
  logic       locked_o;
  logic       de_o;
  logic [1:0] ctrl_o;
  logic [7:0] data_o;

  int checks   = 0;
  int failures = 0;
  int enc_disp = 0;

  always #5 clk = ~clk;

  tmds_rx_align #(
    .LOCK_COUNT(16), .SEARCH_WINDOW(1024), .SLIP_WAIT(4), .LOSS_WINDOW(100)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .tmds_i(tmds_i), .bitslip_o(bitslip_o),
    .locked_o(locked_o), .de_o(de_o), .ctrl_o(ctrl_o), .data_o(data_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int n);
    logic [19:0] t;
    t = {w, w} >> n;
    return t[9:0];
  endfunction

  // Reference DVI encoder with running disparity held in enc_disp
  task automatic tmds_encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1    = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_disp += n0q - n1q;
      else enc_disp += n1q - n0q;
    end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_disp += n1q - n0q - (qm[8] ? 0 : 2);
    end
  endtask

  task automatic test_reset;
    rst_i  = 1'b1;
    tmds_i = 10'h000;
    repeat (3) tick();
    checks++;
    if ({bitslip_o, locked_o, de_o, ctrl_o, data_o} !== 13'h0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0000", {bitslip_o, locked_o, de_o, ctrl_o, data_o});
    end
  endtask

  task automatic test_aligned_lock;
    logic [12:0] exp_v;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tmds_i = 10'h354;
      tick();
      exp_v = {(i >= 15), 1'b0, 1'b0, 2'b00, 8'h00};
      checks++;
      if ({locked_o, bitslip_o, de_o, ctrl_o, data_o} !== exp_v) begin
        failures++;
        $display("FAIL aligned_lock word=%0d got=%h expected=%h", i + 1,
                 {locked_o, bitslip_o, de_o, ctrl_o, data_o}, exp_v);
      end
    end
  endtask

  task automatic test_data_decode;
    logic [9:0] words [2];
    logic [7:0] exp_d [2];
    logic [9:0] q;
    words[0] = 10'h100; exp_d[0] = 8'h00;
    words[1] = 10'h2FF; exp_d[1] = 8'hFE;
    for (int i = 0; i < 2; i++) begin
      tmds_i = words[i];
      tick();
      checks++;
      if ({locked_o, de_o, data_o} !== {1'b1, 1'b1, exp_d[i]}) begin
        failures++;
        $display("FAIL decode_vec word=%h got=%h expected=%h", words[i],
                 {locked_o, de_o, data_o}, {1'b1, 1'b1, exp_d[i]});
      end
    end
    enc_disp = 0;
    for (int v = 0; v < 256; v++) begin
      tmds_encode(v[7:0], q);
      tmds_i = q;
      tick();
      checks++;
      if ({de_o, data_o} !== {1'b1, v[7:0]}) begin
        failures++;
        $display("FAIL roundtrip value=%h word=%h got=%h expected=%h", v[7:0], q,
                 {de_o, data_o}, {1'b1, v[7:0]});
      end
      tmds_i = 10'h354;
      tick();
    end
  endtask

  task automatic test_control_map;
    logic [9:0]  words [4];
    logic [11:0] exp_v [4];
    words[0] = 10'h0AB; exp_v[0] = {1'b1, 1'b0, 2'b01, 8'h00};
    words[1] = 10'h154; exp_v[1] = {1'b1, 1'b0, 2'b10, 8'h00};
    words[2] = 10'h2AB; exp_v[2] = {1'b1, 1'b0, 2'b11, 8'h00};
    words[3] = 10'h100; exp_v[3] = {1'b1, 1'b1, 2'b11, 8'h00};
    for (int i = 0; i < 4; i++) begin
      tmds_i = words[i];
      tick();
      checks++;
      if ({locked_o, de_o, ctrl_o, data_o} !== exp_v[i]) begin
        failures++;
        $display("FAIL control_map word=%h got=%h expected=%h", words[i],
                 {locked_o, de_o, ctrl_o, data_o}, exp_v[i]);
      end
    end
  endtask

  task automatic test_loss_of_lock;
    logic [11:0] exp_v;
    int first;
    tmds_i = 10'h354;
    tick();
    tmds_i = 10'h100;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_v = (i < 100) ? {1'b1, 1'b1, 2'b00, 8'h00} : 12'h000;
      checks++;
      if ({locked_o, de_o, ctrl_o, data_o} !== exp_v) begin
        failures++;
        $display("FAIL loss_of_lock word=%0d got=%h expected=%h", i,
                 {locked_o, de_o, ctrl_o, data_o}, exp_v);
      end
    end
    first = -1;
    for (int j = 1; j <= 1100; j++) begin
      tick();
      if (bitslip_o === 1'b1) begin
        first = j;
        break;
      end
    end
    checks++;
    if (first !== 1024) begin
      failures++;
      $display("FAIL slip_after_loss got_cycle=%0d expected_cycle=1024", first);
    end
  endtask

  task automatic test_reset_mid_wait;
    int first;
    tick();
    rst_i = 1'b1;
    tick();
    checks++;
    if ({bitslip_o, locked_o, de_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_in_wait got=%b expected=000", {bitslip_o, locked_o, de_o});
    end
    rst_i = 1'b0;
    first = -1;
    for (int j = 1; j <= 1100; j++) begin
      tick();
      if (bitslip_o === 1'b1) begin
        first = j;
        break;
      end
    end
    checks++;
    if (first !== 1024) begin
      failures++;
      $display("FAIL slip_after_wait_reset got_cycle=%0d expected_cycle=1024", first);
    end
  endtask

  task automatic test_misaligned;
    int off, pulses, lock_at, exp_pulses, exp_lock;
    for (int k = 0; k < 10; k++) begin
      do_reset();
      off        = k;
      pulses     = 0;
      lock_at    = -1;
      exp_pulses = (10 - k) % 10;
      exp_lock   = (exp_pulses == 0) ? 16 : 1024 + (exp_pulses - 1) * 1029 + 21;
      tmds_i     = rot(10'h354, off);
      for (int c = 1; c <= 12000; c++) begin
        tick();
        if (bitslip_o === 1'b1) begin
          checks++;
          if (c !== 1024 + pulses * 1029) begin
            failures++;
            $display("FAIL slip_spacing k=%0d pulse=%0d got_cycle=%0d expected_cycle=%0d",
                     k, pulses + 1, c, 1024 + pulses * 1029);
          end
          pulses++;
          off = (off + 1) % 10;
        end
        if (locked_o === 1'b1) begin
          lock_at = c;
          break;
        end
        tmds_i = rot(10'h354, off);
      end
      checks++;
      if (pulses !== exp_pulses) begin
        failures++;
        $display("FAIL slip_count k=%0d got=%0d expected=%0d", k, pulses, exp_pulses);
      end
      checks++;
      if (lock_at !== exp_lock) begin
        failures++;
        $display("FAIL lock_cycle k=%0d got=%0d expected=%0d", k, lock_at, exp_lock);
      end
    end
  endtask

  initial begin
    rst_i  = 1'b1;
    tmds_i = 10'h000;
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_control_map();
    test_loss_of_lock();
    test_reset_mid_wait();
    test_misaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_rx_align.md
# tmds_rx_align

TMDS channel receive aligner and decoder: the receive-side counterpart of the 10:1 TMDS serializer output stage. It takes one 10-bit parallel word per pixel clock from an external 1:10 deserializer, finds word alignment by pulsing `bitslip_o` until control-period tokens appear consistently, then decodes TMDS 10b words into 8-bit pixel data, data-enable and control bits. One instance per TMDS data channel, sitting between the deserializer primitives and video timing recovery.

## Interface
- `LOCK_COUNT`, default 16: consecutive control tokens required to declare lock.
- `SEARCH_WINDOW`, default 1024: cycles searched at one slip position before slipping.
- `SLIP_WAIT`, default 4: settle cycles after each bitslip pulse.
- `LOSS_WINDOW`, default 65536: cycles without any control token before lock is dropped.
- Counter widths: `$clog2(param+1)`.

Ports:
- `clk_i` in 1: pixel clock. Sole clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `tmds_i` in 10: deserialized word; bit 0 is the first bit on the wire.
- `bitslip_o` out 1: one-cycle pulse requesting a 1-bit slip of the deserializer.
- `locked_o` out 1: alignment achieved; decoded outputs are valid.
- `de_o` out 1: data-enable, high when the word is a data word.
- `ctrl_o` out 2: control bits {C1,C0}, valid when `de_o`=0.
- `data_o` out 8: decoded pixel byte, valid when `de_o`=1.

## Operation
- Control tokens: 0x354 → ctrl 00; 0x0AB → 01; 0x154 → 10; 0x2AB → 11. Any other value is a data word.
- Data decode: d = q[9] ? ~q[7:0] : q[7:0]. out[0] = d[0]. For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states: SEARCH, SLIP, WAIT, LOCKED. Reset state is SEARCH.
- SEARCH:
  - `run_cnt` increments on each token and clears on any non-token.
  - `win_cnt` increments every cycle.
  - When `run_cnt` reaches LOCK_COUNT, go to LOCKED.
  - Otherwise, when `win_cnt` reaches SEARCH_WINDOW-1, go to SLIP.
  - If both happen in the same cycle, lock wins.
- SLIP: `bitslip_o`=1 for exactly this cycle, then go to WAIT.
- WAIT: count SLIP_WAIT cycles with input ignored, then go to SEARCH with `run_cnt` and `win_cnt` cleared.
- LOCKED:
  - `loss_cnt` clears on each token and increments otherwise.
  - When `loss_cnt` reaches LOSS_WINDOW, go to SEARCH with all counters cleared.
  - No bitslip is issued while LOCKED.
- Outputs while locked:
  - Token word: `de_o`=0, `ctrl_o` = mapped value, `data_o`=0.
  - Data word: `de_o`=1, `ctrl_o` holds its last value, `data_o` = decoded byte.
- Outputs when not locked: `de_o`, `ctrl_o` and `data_o` are forced to 0.
- Reset: all outputs 0 and all counters 0. Reset mid-SLIP or mid-WAIT returns to SEARCH on the next cycle with no further pulse.

## Timing
- `de_o`, `ctrl_o` and `data_o` are registered: 1-cycle latency from `tmds_i`.
- `locked_o` rises the cycle after the LOCK_COUNT-th consecutive token is sampled. The decoded output for that same word appears in that cycle.
- `locked_o` falls the cycle after `loss_cnt` reaches LOSS_WINDOW. Outputs are zeroed in that same cycle.
- Bitslip pulse period during failed search: SEARCH_WINDOW + 1 + SLIP_WAIT cycles (1029 with defaults).
- First pulse after reset: cycle SEARCH_WINDOW, when no tokens are present.

## Test plan
- **Aligned lock:** reset, then 20 words of 0x354 → `locked_o`=1 on the cycle after the 16th word; `bitslip_o` never pulses; `de_o`=0, `ctrl_o`=00.
- **Misaligned by k bits:** continuous 0x354 stream, rotated by k; the bench model rotates by 1 on each pulse → exactly the model-required number of pulses, spaced 1029 cycles apart, followed by lock. Repeat for k = 0..9.
- **Data decode after lock:**
  - 0x100 → `data_o`=0x00, `de_o`=1.
  - 0x2FF → `data_o`=0xFE, `de_o`=1.
  - Full 256-value encoder round-trip matches the bench reference encoder.
- **Control mapping:** 0x0AB, 0x154, 0x2AB → `ctrl_o` = 01, 10, 11 with `de_o`=0. A following data word keeps `ctrl_o`=11.
- **Loss of lock:** with LOSS_WINDOW=100, send 100 data-only words after lock → `locked_o` falls the cycle after the 100th word; outputs go to 0; a slip is issued SEARCH_WINDOW cycles later.
- **Reset mid-WAIT:** assert `rst_i` one cycle into WAIT → state SEARCH, `bitslip_o`=0, and the next pulse comes a full SEARCH_WINDOW after reset release.
